// File: rtl/io_key_sw_device_pkg.sv
// Shared definitions for the KEY/SW memory-mapped responder.
package io_key_sw_device_pkg;

  localparam int unsigned DBITS = 32;

  localparam logic [DBITS-1:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [DBITS-1:0] ADDR_KCTRL = 32'hF000_0110;
  localparam logic [DBITS-1:0] ADDR_SDATA = 32'hF000_0014;
  localparam logic [DBITS-1:0] ADDR_SCTRL = 32'hF000_0114;

  localparam int unsigned CTRL_RDY = 0;
  localparam int unsigned CTRL_OVR = 2;
  localparam int unsigned CTRL_IE  = 8;

  typedef struct packed {
    logic ie;
    logic overrun;
    logic ready;
  } stat_t;

  // Next status for one input group; a commit's overrun set beats a clearing write.
  function automatic stat_t next_stat(stat_t cur, logic commit, logic rd_clr,
                                      logic wr_ctrl, logic wr_ovr, logic wr_ie);
    stat_t nxt;
    nxt = cur;
    if (wr_ctrl) begin
      nxt.ie = wr_ie;
      if (!wr_ovr) nxt.overrun = 1'b0;
    end
    if (rd_clr) nxt.ready = 1'b0;
    if (commit) begin
      nxt.ready = 1'b1;
      if (cur.ready && !rd_clr) nxt.overrun = 1'b1;
    end
    return nxt;
  endfunction

  // Control/status register read view.
  function automatic logic [DBITS-1:0] ctrl_word(stat_t s);
    logic [DBITS-1:0] w;
    w           = '0;
    w[CTRL_RDY] = s.ready;
    w[CTRL_OVR] = s.overrun;
    w[CTRL_IE]  = s.ie;
    return w;
  endfunction

endpackage

// File: rtl/io_key_sw_device_if.sv
// CPU data-memory port as seen by the KEY/SW responder.
interface io_key_sw_device_if;
  import io_key_sw_device_pkg::*;

  logic [DBITS-1:0] addr;
  logic             rd_en;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;
  logic             sel;

  modport master (output addr, rd_en, wr_en, wdata, input rdata, sel);
  modport slave  (input addr, rd_en, wr_en, wdata, output rdata, sel);
endinterface

// File: rtl/io_key_sw_device_debounce.sv
// Two-flop synchroniser plus stability counter; holds the committed value.
module io_key_sw_device_debounce #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] data_o,
  output logic             commit_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Strobe high for the one cycle in which a stable, new value is taken.
  assign commit_o = (cnt_q == CNT_MAX) && (cand_q != data_q);
  assign data_o   = data_q;

  // Candidate tracking and saturating stability count.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (commit_o) data_d = cand_q;
  end

  // State registers; reset discards any candidate in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/io_key_sw_device.sv
// Memory-mapped KEY/SW responder: decode, data/status registers, interrupt.
module io_key_sw_device
  import io_key_sw_device_pkg::*;
#(
  parameter int unsigned KEY_BITS        = 4,
  parameter int unsigned SW_BITS         = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic                clk,
  input  logic                reset,
  io_key_sw_device_if.slave   bus,
  input  logic [KEY_BITS-1:0] KEY,
  input  logic [SW_BITS-1:0]  SW,
  output logic                irq
);

  logic [KEY_BITS-1:0] key_pressed, kdata;
  logic [SW_BITS-1:0]  sdata;
  logic                k_commit, s_commit;
  logic                hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
  logic                rd_only;
  logic [DBITS-1:0]    rdata_c;
  stat_t               k_q, k_d, s_q, s_d;
  logic                irq_q, irq_d;
  logic                unused_wdata;

  // Buttons are active-low on the board; present them as 1 = pressed.
  assign key_pressed = ~KEY;

  io_key_sw_device_debounce #(.WIDTH(KEY_BITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk(clk), .reset(reset), .raw_i(key_pressed), .data_o(kdata), .commit_o(k_commit)
  );

  io_key_sw_device_debounce #(.WIDTH(SW_BITS), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk(clk), .reset(reset), .raw_i(SW), .data_o(sdata), .commit_o(s_commit)
  );

  assign hit_kdata = (bus.addr == ADDR_KDATA);
  assign hit_kctrl = (bus.addr == ADDR_KCTRL);
  assign hit_sdata = (bus.addr == ADDR_SDATA);
  assign hit_sctrl = (bus.addr == ADDR_SCTRL);
  // A simultaneous load and store behaves as a store only.
  assign rd_only   = bus.rd_en & ~bus.wr_en;

  assign unused_wdata = ^{bus.wdata[DBITS-1:CTRL_IE+1], bus.wdata[CTRL_IE-1:CTRL_OVR+1],
                          bus.wdata[CTRL_OVR-1:0]};

  // Combinational read mux and select.
  always_comb begin
    rdata_c = '0;
    if (hit_kdata)      rdata_c = DBITS'(kdata);
    else if (hit_kctrl) rdata_c = ctrl_word(k_q);
    else if (hit_sdata) rdata_c = DBITS'(sdata);
    else if (hit_sctrl) rdata_c = ctrl_word(s_q);
  end

  assign bus.rdata = rdata_c;
  assign bus.sel   = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

  // Status next-state for both groups.
  always_comb begin
    k_d = next_stat(k_q, k_commit, rd_only & hit_kdata, bus.wr_en & hit_kctrl,
                    bus.wdata[CTRL_OVR], bus.wdata[CTRL_IE]);
    s_d = next_stat(s_q, s_commit, rd_only & hit_sdata, bus.wr_en & hit_sctrl,
                    bus.wdata[CTRL_OVR], bus.wdata[CTRL_IE]);
  end

  assign irq_d = (k_q.ready & k_q.ie) | (s_q.ready & s_q.ie);
  assign irq   = irq_q;

  // Status and interrupt registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      k_q   <= '0;
      s_q   <= '0;
      irq_q <= 1'b0;
    end else begin
      k_q   <= k_d;
      s_q   <= s_d;
      irq_q <= irq_d;
    end
  end

endmodule
